// File: rtl/conv_layer_sequencer_if.sv
// ----------------------------------------------------------------------------
// conv_layer_sequencer_if
//   Pixel path and layer status bundle around conv_layer_sequencer.
//
//   Upstream side : in_valid / in_data  -> sequencer, in_ready <- sequencer
//   Layer side    : out_valid / out_data -> layer in_valid / in_data
//                   layer_buffer_done / layer_pooling_done -> sequencer
//
//   slave  : the sequencer's view (consumes upstream pixels, drives the layer)
//   master : the environment's view (upstream source plus layer status)
// ----------------------------------------------------------------------------
interface conv_layer_sequencer_if #(
    parameter int unsigned BitSize = 32
);
    logic               in_valid;
    logic [BitSize-1:0] in_data;
    logic               in_ready;
    logic               out_valid;
    logic [BitSize-1:0] out_data;
    logic               layer_buffer_done;
    logic               layer_pooling_done;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  layer_buffer_done,
        input  layer_pooling_done
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output layer_buffer_done,
        output layer_pooling_done
    );
endinterface

// File: rtl/conv_layer_sequencer.sv
// ----------------------------------------------------------------------------
// conv_layer_sequencer
//   Frame-level controller in front of one conv_pooling_layer. Forwards
//   exactly ImageWidth*ImageWidth upstream pixels per frame, spaced at least
//   CyclesPerPixel cycles apart, then waits (bounded by DrainTimeout) for the
//   layer's pooling_done before pulsing frame_done.
//
//   Ports:
//     clk        : clock, all state on rising edge
//     res_n      : asynchronous active-low reset
//     start      : begin a frame (only looked at in IDLE)
//     bus        : pixel in (valid/ready), pixel out to layer (registered),
//                  layer buffer_done / pooling_done status
//     busy       : high whenever not IDLE
//     frame_done : one-cycle pulse while in DONE
//     error      : sticky; drain timeout or buffer_done seen while feeding,
//                  cleared by the next accepted start
// ----------------------------------------------------------------------------
module conv_layer_sequencer #(
    parameter int unsigned BitSize        = 32,
    parameter int unsigned ImageWidth     = 4,
    parameter int unsigned CyclesPerPixel = 2,
    parameter int unsigned DrainTimeout   = 64
) (
    input  logic                  clk,
    input  logic                  res_n,
    input  logic                  start,
    conv_layer_sequencer_if.slave bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  error
);

    localparam int unsigned Pixels = ImageWidth * ImageWidth;
    localparam int unsigned PixW   = $clog2(Pixels + 1);
    localparam int unsigned PaceW  = $clog2(CyclesPerPixel + 1);
    localparam int unsigned TimerW = $clog2(DrainTimeout + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [PixW-1:0]    r_pixel_cnt;
    logic [PaceW-1:0]   r_pace_cnt;
    logic [TimerW-1:0]  r_timer;
    logic               r_out_valid;
    logic [BitSize-1:0] r_out_data;
    logic               r_error;

    state_t             w_state_next;
    logic [PixW-1:0]    w_pixel_next;
    logic [PaceW-1:0]   w_pace_next;
    logic [TimerW-1:0]  w_timer_next;
    logic               w_out_valid_next;
    logic [BitSize-1:0] w_out_data_next;
    logic               w_error_next;
    logic               w_in_ready;
    logic               w_accept;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state     <= S_IDLE;
            r_pixel_cnt <= '0;
            r_pace_cnt  <= '0;
            r_timer     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pixel_cnt <= w_pixel_next;
            r_pace_cnt  <= w_pace_next;
            r_timer     <= w_timer_next;
            r_out_valid <= w_out_valid_next;
            r_out_data  <= w_out_data_next;
            r_error     <= w_error_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pixel_next     = r_pixel_cnt;
        w_pace_next      = r_pace_cnt;
        w_timer_next     = r_timer;
        w_out_valid_next = 1'b0;
        w_out_data_next  = r_out_data;
        w_error_next     = r_error;
        w_in_ready       = 1'b0;
        w_accept         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FEED;
                    w_pixel_next = '0;
                    w_pace_next  = '0;
                    w_error_next = 1'b0;
                end
            end

            S_FEED: begin
                // Ready depends only on the pacing counter so upstream never
                // sees a combinational path from its own valid.
                w_in_ready = (r_pace_cnt == '0);
                w_accept   = bus.in_valid && w_in_ready;
                if (w_accept) begin
                    w_out_valid_next = 1'b1;
                    w_out_data_next  = bus.in_data;
                    w_pixel_next     = r_pixel_cnt + PixW'(1);
                    w_pace_next      = PaceW'(CyclesPerPixel - 1);
                    if (r_pixel_cnt == PixW'(Pixels - 1)) begin
                        w_state_next = S_DRAIN;
                        w_timer_next = '0;
                    end
                end else if (r_pace_cnt != '0) begin
                    w_pace_next = r_pace_cnt - PaceW'(1);
                end
                // The layer cannot legitimately finish its buffer before the
                // last pixel has been delivered.
                if (bus.layer_buffer_done) begin
                    w_error_next = 1'b1;
                end
            end

            S_DRAIN: begin
                // pooling_done takes priority over a coincident timeout.
                if (bus.layer_pooling_done) begin
                    w_state_next = S_DONE;
                end else begin
                    w_timer_next = r_timer + TimerW'(1);
                    if (r_timer == TimerW'(DrainTimeout - 1)) begin
                        w_error_next = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign busy          = (r_state != S_IDLE);
    assign frame_done    = (r_state == S_DONE);
    assign error         = r_error;

endmodule
